// File: rtl/wishbone_classic_arbiter_if.sv
// rtl/wishbone_classic_arbiter_if.sv - Bundle of controller-side and device-side Wishbone classic signals
//
// Parameters: N_CTRL controllers, AW address bits, DW data bits.
// Controller side: c_cyc_i/c_stb_i/c_we_i (N_CTRL), c_adr_i/c_dat_i/c_sel_i packed per controller,
//                  c_dat_o (broadcast), c_ack_o/c_err_o (N_CTRL).
// Device side:     d_cyc_o/d_stb_o/d_we_o/d_adr_o/d_dat_o/d_sel_o, d_dat_i/d_ack_i/d_err_i.
// Modport slave is the arbiter's view; modport master is the view of whoever drives the arbiter.
interface wishbone_classic_arbiter_if #(
    parameter int N_CTRL = 2,
    parameter int AW     = 32,
    parameter int DW     = 32
);
    logic [N_CTRL-1:0]        c_cyc_i;
    logic [N_CTRL-1:0]        c_stb_i;
    logic [N_CTRL-1:0]        c_we_i;
    logic [N_CTRL*AW-1:0]     c_adr_i;
    logic [N_CTRL*DW-1:0]     c_dat_i;
    logic [N_CTRL*DW/8-1:0]   c_sel_i;
    logic [DW-1:0]            c_dat_o;
    logic [N_CTRL-1:0]        c_ack_o;
    logic [N_CTRL-1:0]        c_err_o;

    logic                     d_cyc_o;
    logic                     d_stb_o;
    logic                     d_we_o;
    logic [AW-1:0]            d_adr_o;
    logic [DW-1:0]            d_dat_o;
    logic [DW/8-1:0]          d_sel_o;
    logic [DW-1:0]            d_dat_i;
    logic                     d_ack_i;
    logic                     d_err_i;

    modport slave (
        input  c_cyc_i, c_stb_i, c_we_i, c_adr_i, c_dat_i, c_sel_i,
        input  d_dat_i, d_ack_i, d_err_i,
        output c_dat_o, c_ack_o, c_err_o,
        output d_cyc_o, d_stb_o, d_we_o, d_adr_o, d_dat_o, d_sel_o
    );

    modport master (
        output c_cyc_i, c_stb_i, c_we_i, c_adr_i, c_dat_i, c_sel_i,
        output d_dat_i, d_ack_i, d_err_i,
        input  c_dat_o, c_ack_o, c_err_o,
        input  d_cyc_o, d_stb_o, d_we_o, d_adr_o, d_dat_o, d_sel_o
    );
endinterface

// File: rtl/wishbone_classic_arbiter.sv
// rtl/wishbone_classic_arbiter.sv - Round-robin arbiter sharing one Wishbone classic device among N_CTRL controllers
//
// Ports: clk_i (rising edge), rst_ni (synchronous, active-low), bus (wishbone_classic_arbiter_if.slave).
// Parameters: N_CTRL (2..8), AW, DW (multiple of 8), TIMEOUT_CYCLES.
// Optional feature: define WB_ARB_TIMEOUT_EN to add a watchdog that errors a stalled owner
// after TIMEOUT_CYCLES unacknowledged strobe cycles; without it the arbiter waits indefinitely.
module wishbone_classic_arbiter #(
    parameter int N_CTRL         = 2,
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    wishbone_classic_arbiter_if.slave   bus
);
    localparam int IW = $clog2(N_CTRL);
    localparam int SW = DW / 8;

    if (N_CTRL < 2 || N_CTRL > 8 || (DW % 8) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("wishbone_classic_arbiter: illegal parameter value");
    end

    typedef enum logic {IDLE, OWNED} state_t;

    state_t          state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   last;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   cand;
    logic            found;
    logic            owned;
    logic            tmo_hit;

    logic [AW-1:0]   adr_a [N_CTRL];
    logic [DW-1:0]   dat_a [N_CTRL];
    logic [SW-1:0]   sel_a [N_CTRL];

    assign owned = (state == OWNED);

    // Round-robin search starting just after the last granted controller; the
    // final candidate is 'last' itself, so a lone requester wins again.
    always_comb begin
        pick  = last;
        cand  = '0;
        found = 1'b0;
        for (int i = 1; i <= N_CTRL; i++) begin
            cand = IW'((int'(last) + i) % N_CTRL);
            if (!found && bus.c_cyc_i[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    assign tmo_hit = owned && (tmo_cnt == TW'(TIMEOUT_CYCLES));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
            owner <= '0;
            last  <= IW'(N_CTRL - 1);
`ifdef WB_ARB_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.c_cyc_i) begin
                        state <= OWNED;
                        owner <= pick;
                    end
                end
                OWNED: begin
                    if (!bus.c_cyc_i[owner]) begin
                        state <= IDLE;
                        last  <= owner;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef WB_ARB_TIMEOUT_EN
            // The forced-low strobe on the timeout cycle makes the counter clear itself.
            if (bus.d_stb_o && !bus.d_ack_i && !bus.d_err_i)
                tmo_cnt <= tmo_cnt + 1'b1;
            else
                tmo_cnt <= '0;
`endif
        end
    end

    for (genvar k = 0; k < N_CTRL; k++) begin : g_ctrl
        assign adr_a[k] = bus.c_adr_i[k*AW +: AW];
        assign dat_a[k] = bus.c_dat_i[k*DW +: DW];
        assign sel_a[k] = bus.c_sel_i[k*SW +: SW];
        assign bus.c_ack_o[k] = owned && (owner == IW'(k)) && bus.d_ack_i;
        assign bus.c_err_o[k] = owned && (owner == IW'(k)) && (bus.d_err_i || tmo_hit);
    end

    assign bus.d_cyc_o = owned && bus.c_cyc_i[owner];
    assign bus.d_stb_o = owned && bus.c_stb_i[owner] && !tmo_hit;
    assign bus.d_we_o  = owned && bus.c_we_i[owner];
    assign bus.d_adr_o = owned ? adr_a[owner] : '0;
    assign bus.d_dat_o = owned ? dat_a[owner] : '0;
    assign bus.d_sel_o = owned ? sel_a[owner] : '0;
    assign bus.c_dat_o = bus.d_dat_i;

endmodule

// File: tb/tb_wishbone_classic_arbiter.sv
// tb/tb_wishbone_classic_arbiter.sv - Directed scoreboard bench for wishbone_classic_arbiter with three controllers
module tb_wishbone_classic_arbiter;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    cyc, stb, we;
    logic [AW-1:0]   adr [N];
    logic [DW-1:0]   dat [N];
    logic [DW/8-1:0] sel [N];
    logic [DW-1:0]   d_dat;
    logic            d_ack, d_err;

    wishbone_classic_arbiter_if #(.N_CTRL(N), .AW(AW), .DW(DW)) bus ();

    assign bus.c_cyc_i = cyc;
    assign bus.c_stb_i = stb;
    assign bus.c_we_i  = we;
    assign bus.d_dat_i = d_dat;
    assign bus.d_ack_i = d_ack;
    assign bus.d_err_i = d_err;
    for (genvar k = 0; k < N; k++) begin : g_pack
        assign bus.c_adr_i[k*AW +: AW]     = adr[k];
        assign bus.c_dat_i[k*DW +: DW]     = dat[k];
        assign bus.c_sel_i[k*DW/8 +: DW/8] = sel[k];
    end

    wishbone_classic_arbiter #(.N_CTRL(N), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(16)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Each controller uses a distinct address, so the device-side address names the owner.
    function automatic int owner_of(input logic [AW-1:0] a);
        if (a == 32'h0000_0100) return 0;
        if (a == 32'h0000_0010) return 1;
        if (a == 32'h0000_0200) return 2;
        return 7;
    endfunction

    // Wait (bounded) for a negedge with d_cyc_o high and score the owner against the queue.
    task automatic observe_grant(output int waited, output int exp_owner);
        int who;
        who = -1;
        waited = -1;
        exp_owner = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.d_cyc_o === 1'b1) begin
                who = owner_of(bus.d_adr_o);
                waited = n;
                break;
            end
        end
        if (who < 0) check("grant_wait", 64'(0), 64'(1));
        if (exp_q.size() == 0) begin
            check("sb_empty", 64'(who), 64'(-1));
        end else begin
            exp_owner = exp_q.pop_front();
            check("grant_owner", 64'(who), 64'(exp_owner));
        end
    endtask

    int w, e;
    logic [N-1:0] exp_err;

    initial begin
        cyc = '0; stb = '0; we = '0;
        adr[0] = 32'h0000_0100; adr[1] = 32'h0000_0010; adr[2] = 32'h0000_0200;
        dat[0] = 32'h0000_0000; dat[1] = 32'hDEAD_BEEF; dat[2] = 32'h2222_2222;
        sel[0] = 4'hF; sel[1] = 4'hF; sel[2] = 4'hF;
        d_dat = '0; d_ack = 1'b1; d_err = 1'b1;

        // Reset: bus idle and no responses even with the device asserting ack/err.
        tick(); tick();
        @(negedge clk);
        check("rst_d_cyc", 64'(bus.d_cyc_o), 64'(0));
        check("rst_d_stb", 64'(bus.d_stb_o), 64'(0));
        check("rst_c_ack", 64'(bus.c_ack_o), 64'(0));
        check("rst_c_err", 64'(bus.c_err_o), 64'(0));

        // Controllers 0 and 1 request as reset releases; 0 wins after one cycle.
        tick();
        d_ack = 1'b0; d_err = 1'b0;
        cyc = 3'b011; stb = 3'b011; we = 3'b010;
        rst_ni = 1'b1;
        exp_q.push_back(0);
        observe_grant(w, e);
        check("grant_latency", 64'(w), 64'(1));

        // Waiting controller 1 must not see the owner's ack.
        tick();
        d_ack = 1'b1;
        @(negedge clk);
        check("ack_owner0_only", 64'(bus.c_ack_o), 64'(3'b001));

        // Owner releases; controller 1 granted after exactly one IDLE cycle.
        tick();
        d_ack = 1'b0;
        cyc = 3'b010; stb = 3'b010;
        exp_q.push_back(1);
        observe_grant(w, e);
        check("idle_gap", 64'(w), 64'(2));

        // Write by controller 1.
        tick();
        d_ack = 1'b1;
        @(negedge clk);
        check("wr_adr", 64'(bus.d_adr_o), 64'(32'h10));
        check("wr_dat", 64'(bus.d_dat_o), 64'(32'hDEAD_BEEF));
        check("wr_we", 64'(bus.d_we_o), 64'(1));
        check("wr_sel", 64'(bus.d_sel_o), 64'(4'hF));
        check("wr_ack", 64'(bus.c_ack_o), 64'(3'b010));

        // Read by controller 1: data passes through in the same cycle.
        tick();
        we = 3'b000;
        d_dat = 32'h1234_5678;
        @(negedge clk);
        check("rd_dat", 64'(bus.c_dat_o), 64'(32'h1234_5678));
        check("rd_ack", 64'(bus.c_ack_o), 64'(3'b010));
        check("rd_we", 64'(bus.d_we_o), 64'(0));

        // Device error routed to the owner only.
        tick();
        d_ack = 1'b0; d_err = 1'b1;
        @(negedge clk);
        check("err_route", 64'(bus.c_err_o), 64'(3'b010));

        // Lone requester is re-granted after its IDLE gap.
        tick();
        d_err = 1'b0;
        cyc = 3'b000; stb = 3'b000;
        @(negedge clk);
        check("release_cyc", 64'(bus.d_cyc_o), 64'(0));
        tick();
        cyc = 3'b010; stb = 3'b010;
        exp_q.push_back(1);
        observe_grant(w, e);
        check("regrant_latency", 64'(w), 64'(1));

        // Round robin from reset: all request continuously, each releases after one ack.
        tick();
        rst_ni = 1'b0;
        cyc = 3'b111; stb = 3'b111;
        tick();
        rst_ni = 1'b1;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        exp_q.push_back(0); exp_q.push_back(1);
        for (int g = 0; g < 5; g++) begin
            observe_grant(w, e);
            tick();
            d_ack = 1'b1;
            @(negedge clk);
            check("rr_ack", 64'(bus.c_ack_o), 64'(3'b001 << e));
            tick();
            d_ack = 1'b0;
            cyc = cyc & ~(3'b001 << e);
            stb = stb & ~(3'b001 << e);
            tick();
            cyc = cyc | (3'b001 << e);
            stb = stb | (3'b001 << e);
        end

        // Reset while controller 0 waits for its ack.
        tick();
        rst_ni = 1'b0;
        cyc = 3'b000; stb = 3'b000;
        tick();
        rst_ni = 1'b1;
        cyc = 3'b001; stb = 3'b001;
        exp_q.push_back(0);
        observe_grant(w, e);
        tick();
        rst_ni = 1'b0;
        tick();
        d_ack = 1'b1;
        @(negedge clk);
        check("midrst_cyc", 64'(bus.d_cyc_o), 64'(0));
        check("midrst_ack", 64'(bus.c_ack_o), 64'(0));

        // Device never responds: watchdog behaviour depends on the build.
        tick();
        rst_ni = 1'b1;
        d_ack = 1'b0;
        exp_q.push_back(0);
        observe_grant(w, e);
        check("stall_latency", 64'(w), 64'(1));
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
`ifdef WB_ARB_TIMEOUT_EN
            exp_err = ((i % 17) == 16) ? 3'b001 : 3'b000;
            check("tmo_stb", 64'(bus.d_stb_o), 64'(~exp_err[0]));
`else
            exp_err = 3'b000;
`endif
            check("tmo_err", 64'(bus.c_err_o), 64'(exp_err));
        end

        check("sb_drained", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wishbone_classic_arbiter.md
WISHBONE_CLASSIC_ARBITER -- requirements
Module: wishbone_classic_arbiter

Interface
REQ-001 SHALL have parameter N_CTRL, default 2, number of Wishbone classic controllers sharing one device (range 2..8).
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter DW, default 32, data width (multiple of 8).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16, watchdog limit (used only under REQ-027).
REQ-005 SHALL have port clk_i  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-007 SHALL have ports c_cyc_i, c_stb_i, c_we_i  input  N_CTRL each  per-controller cycle, strobe and write enable.
REQ-008 SHALL have port c_adr_i  input  N_CTRL*AW  packed per-controller addresses, controller k at [k*AW +: AW].
REQ-009 SHALL have port c_dat_i  input  N_CTRL*DW  packed per-controller write data.
REQ-010 SHALL have port c_sel_i  input  N_CTRL*DW/8  packed per-controller byte selects.
REQ-011 SHALL have port c_dat_o  output  DW  read data, broadcast to all controllers.
REQ-012 SHALL have ports c_ack_o, c_err_o  output  N_CTRL each  per-controller ack and error.
REQ-013 SHALL have ports d_cyc_o, d_stb_o, d_we_o  output  1 each  device-side cycle, strobe, write enable.
REQ-014 SHALL have ports d_adr_o (AW), d_dat_o (DW), d_sel_o (DW/8)  output  device-side address, write data, byte select.
REQ-015 SHALL have ports d_dat_i (DW), d_ack_i (1), d_err_i (1)  input  device-side read data, ack, error.

Function
REQ-016 SHALL implement states IDLE and OWNED; owner index (clog2(N_CTRL) bits) and last-granted index SHALL be registered.
REQ-017 In IDLE with any c_cyc_i high, SHALL select the first requester searching from (last+1) mod N_CTRL upward with wrap-around, and enter OWNED with that owner on the next edge.
REQ-018 Grant latency SHALL be exactly one cycle: c_cyc_i[k] high at edge n yields d_cyc_o high after edge n+1 if k wins.
REQ-019 In OWNED, d_cyc_o/d_stb_o/d_we_o/d_adr_o/d_dat_o/d_sel_o SHALL combinationally equal the owner's inputs; in IDLE d_cyc_o and d_stb_o SHALL be 0.
REQ-020 c_ack_o[owner]=d_ack_i and c_err_o[owner]=d_err_i in OWNED; all other c_ack_o/c_err_o bits SHALL be 0; c_dat_o=d_dat_i always.
REQ-021 Ownership SHALL be held while c_cyc_i[owner] is high, regardless of other requests (no preemption).
REQ-022 When c_cyc_i[owner] is low in OWNED, SHALL return to IDLE on the next edge and set last=owner; at least one IDLE cycle SHALL separate consecutive grants.
REQ-023 A controller raising c_cyc_i while another owns the bus SHALL see no ack/err until granted.
REQ-024 Single requester SHALL be re-granted after its IDLE gap (round-robin wraps to itself).

Reset
REQ-025 rst_ni low at a rising edge SHALL force IDLE, last=N_CTRL-1 (so controller 0 wins first), timeout counter 0; d_cyc_o=d_stb_o=0 and all c_ack_o/c_err_o=0 in the following cycle.
REQ-026 Reset asserted mid-transaction SHALL drop d_cyc_o after that edge with no ack/err delivered to the former owner.

Configuration
REQ-027 Macro WB_ARB_TIMEOUT_EN defined: counter increments each OWNED cycle with d_stb_o=1 and d_ack_i=d_err_i=0, clears otherwise; on reaching TIMEOUT_CYCLES, c_err_o[owner] SHALL pulse one cycle, d_stb_o SHALL be forced 0 that cycle, counter SHALL clear.
REQ-028 Macro undefined: no counter logic; arbiter waits indefinitely for d_ack_i/d_err_i; c_err_o driven only by REQ-020.

Verification
REQ-029 Reset release, c_cyc_i=2'b11 same cycle -> controller 0 owns after 1 cycle; controller 1 granted 1 IDLE cycle after c_cyc_i[0] drops.
REQ-030 Controller 1 owns, device acks write adr 0x10 data 0xDEADBEEF -> d_adr_o=0x10, d_dat_o=0xDEADBEEF, c_ack_o=2'b10, c_ack_o[0]=0.
REQ-031 Read: d_dat_i=0x12345678 with d_ack_i -> c_dat_o=0x12345678 same cycle to owner.
REQ-032 N_CTRL=3, all request continuously, each releasing after one ack -> grant order 0,1,2,0,1.
REQ-033 rst_ni low while controller 0 waits for ack -> d_cyc_o=0 next cycle; c_ack_o=0 even if d_ack_i=1.
REQ-034 WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, device never acks -> c_err_o[owner]=1 exactly 16 cycles after d_stb_o rises; undefined macro -> no err after 100 cycles.
